perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter N_CNT, default 5, number of independent counter channels (1..16).
REQ-002 SHALL have parameter CNT_W, default PERF_CNT_LEN (64), counter width in bits.
REQ-003 SHALL have parameter XLEN, default XLEN (32), access-port width; CNT_W SHALL be XLEN or 2*XLEN.
REQ-004 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port evt_i  input  N_CNT  per-channel increment strobe, +PERF_CNT_INC when high.
REQ-007 SHALL have port inhibit_i  input  N_CNT  per-channel freeze; a high bit blocks that channel's increment.
REQ-008 SHALL have port rd_en_i  input  1  read request.
REQ-009 SHALL have port rd_idx_i  input  4  channel index for read.
REQ-010 SHALL have port rd_hi_i  input  1  selects the upper XLEN half.
REQ-011 SHALL have port rd_data_o  output  XLEN  read data, registered.
REQ-012 SHALL have port rd_valid_o  output  1  one-cycle pulse qualifying rd_data_o.
REQ-013 SHALL have port wr_en_i  input  1  write request.
REQ-014 SHALL have port wr_idx_i  input  4  channel index for write.
REQ-015 SHALL have port wr_hi_i  input  1  selects the upper half for write.
REQ-016 SHALL have port wr_data_i  input  XLEN  write data.
REQ-017 SHALL have port ovf_o  output  N_CNT  sticky per-channel wrap flag.

Function
REQ-018 SHALL increment channel k by PERF_CNT_INC each cycle where evt_i[k]=1 and inhibit_i[k]=0.
REQ-019 SHALL wrap all-ones to zero and set ovf_o[k] in that same edge.
REQ-020 SHALL return rd_data_o and rd_valid_o=1 exactly one cycle after rd_en_i=1; rd_valid_o SHALL be 0 otherwise.
REQ-021 SHALL return the counter value as of the rd_en_i edge, excluding any increment in that same cycle.
REQ-022 SHALL return 0 with rd_valid_o=1 when rd_idx_i >= N_CNT or when rd_hi_i=1 and CNT_W=XLEN.
REQ-023 SHALL replace only the addressed half on write; the other half is unchanged and no carry propagates.
REQ-024 SHALL give a write priority over an increment on the same channel in the same cycle; no increment is applied.
REQ-025 SHALL clear ovf_o[k] on any write to channel k.
REQ-026 SHALL ignore writes with wr_idx_i >= N_CNT, and writes with wr_hi_i=1 when CNT_W=XLEN.
REQ-027 SHALL see a read and a write to the same channel in one cycle return the pre-write value.
REQ-028 SHALL carry into the upper half when the lower half wraps (CNT_W=2*XLEN).

Reset
REQ-029 SHALL, on rst high, clear every counter, ovf_o, rd_data_o, rd_valid_o and the snapshot register immediately, independent of clk.
REQ-030 SHALL discard any read in flight on reset mid-operation; rd_valid_o is 0 on the first edge after release.

Configuration
REQ-031 SHALL, with PERF_CNT_SNAPSHOT_EN defined, latch the upper half of the channel when its lower half is read.
REQ-032 With PERF_CNT_SNAPSHOT_EN, a following rd_hi_i read of the same channel SHALL return the latched value.
REQ-033 Without PERF_CNT_SNAPSHOT_EN, the snapshot register SHALL not exist and rd_hi_i reads SHALL return the live upper half.

Structure
REQ-034 SHALL take PERF_CNT_LEN, PERF_CNT_INC and a new PERF_CNT_MAX_CH (16) from core_config_pkg.
REQ-035 SHALL add a perf_event_t enum (cycle, instr, flush, wait, decod) to core_config_pkg, mapping evt_i bit order.
REQ-036 SHALL instantiate one sub-module perf_counter_cell per channel, holding the count, increment/write priority and ovf.

Verification
REQ-037 Counter 0 at 0x0000_0000_FFFF_FFFF, evt_i[0]=1 for 1 cycle -> low read 0x0000_0000, high read 0x0000_0001, ovf_o[0]=0.
REQ-038 Write low 0xFFFF_FFFF and high 0xFFFF_FFFF to ch2, one event -> ch2 reads 0, ovf_o[2]=1; next write to ch2 -> ovf_o[2]=0.
REQ-039 Inhibit and write collision: ch1 inhibited, evt_i[1]=1 for 10 cycles -> unchanged; write 5 with evt_i[1]=1 same cycle -> reads 5.
REQ-040 PERF_CNT_SNAPSHOT_EN: ch0=0x1_FFFF_FFFF, read low, 1 event, read high -> 0xFFFF_FFFF then 0x0000_0001 (without the macro: 0x0000_0002).
REQ-041 rd_idx_i=15 with N_CNT=5 -> rd_data_o=0, rd_valid_o=1 after 1 cycle; wr_idx_i=15 -> no channel changes.
REQ-042 Assert rst while rd_en_i is high, count at 100 -> all outputs 0 without a clk edge, rd_valid_o low after release.

Source files
------------

// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the performance counter bank.
// The evt_i bit order of perf_counter_bank follows perf_event_t.
package core_config_pkg;

    localparam int CORE_XLEN       = 32;
    localparam int PERF_CNT_LEN    = 64;
    localparam int PERF_CNT_INC    = 1;
    localparam int PERF_CNT_MAX_CH = 16;

    typedef enum logic [2:0] {
        PERF_EVT_CYCLE = 3'd0,
        PERF_EVT_INSTR = 3'd1,
        PERF_EVT_FLUSH = 3'd2,
        PERF_EVT_WAIT  = 3'd3,
        PERF_EVT_DECOD = 3'd4
    } perf_event_t;

endpackage

// File: rtl/perf_counter_cell.sv
// One performance counter channel: count register, write-over-increment
// priority and a sticky wrap flag. Exposes the count as two XLEN halves.
module perf_counter_cell
    import core_config_pkg::*;
#(
    parameter int CNT_W = PERF_CNT_LEN,
    parameter int XLEN  = CORE_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_en,
    input  logic            wr_lo,
    input  logic            wr_hi,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] count_lo,
    output logic [XLEN-1:0] count_hi,
    output logic            ovf
);

    localparam bit WIDE = (CNT_W == 2 * XLEN);

    logic [CNT_W-1:0] count_r;
    logic             ovf_r;
    logic [CNT_W:0]   sum_s;
    logic [CNT_W-1:0] wr_val_s;
    logic             wr_any_s;

    // The extra sum bit is the wrap indication for the sticky flag.
    assign sum_s    = {1'b0, count_r} + (CNT_W + 1)'(PERF_CNT_INC);
    assign wr_any_s = wr_lo | (wr_hi & WIDE);

    generate
        if (WIDE) begin : g_wide
            // Merge write data into the addressed half only
            always_comb begin
                wr_val_s = count_r;
                if (wr_lo) begin
                    wr_val_s[XLEN-1:0] = wr_data;
                end else if (wr_hi) begin
                    wr_val_s[CNT_W-1:XLEN] = wr_data;
                end else begin
                    wr_val_s = count_r;
                end
            end
            assign count_lo = count_r[XLEN-1:0];
            assign count_hi = count_r[CNT_W-1:XLEN];
        end else begin : g_narrow
            assign wr_val_s = wr_data;
            assign count_lo = count_r;
            assign count_hi = {XLEN{1'b0}};
        end
    endgenerate

    // Count and wrap-flag state; a write beats a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
        end else if (wr_any_s) begin
            count_r <= wr_val_s;
            ovf_r   <= 1'b0;
        end else if (inc_en) begin
            count_r <= sum_s[CNT_W-1:0];
            ovf_r   <= ovf_r | sum_s[CNT_W];
        end else begin
            count_r <= count_r;
            ovf_r   <= ovf_r;
        end
    end

    assign ovf = ovf_r;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of N_CNT performance counters with an XLEN-wide read/write port.
// Optional macro PERF_CNT_SNAPSHOT_EN: a low-half read latches the upper half for a later high read.
module perf_counter_bank
    import core_config_pkg::*;
#(
    parameter int N_CNT = 5,
    parameter int CNT_W = PERF_CNT_LEN,
    parameter int XLEN  = CORE_XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CNT-1:0] evt_i,
    input  logic [N_CNT-1:0] inhibit_i,
    input  logic             rd_en_i,
    input  logic [3:0]       rd_idx_i,
    input  logic             rd_hi_i,
    output logic [XLEN-1:0]  rd_data_o,
    output logic             rd_valid_o,
    input  logic             wr_en_i,
    input  logic [3:0]       wr_idx_i,
    input  logic             wr_hi_i,
    input  logic [XLEN-1:0]  wr_data_i,
    output logic [N_CNT-1:0] ovf_o
);

    localparam bit WIDE = (CNT_W == 2 * XLEN);

    logic [N_CNT-1:0] inc_en_s;
    logic [N_CNT-1:0] wr_lo_s;
    logic [N_CNT-1:0] wr_hi_s;
    logic [XLEN-1:0]  cnt_lo_s [N_CNT];
    logic [XLEN-1:0]  cnt_hi_s [N_CNT];
    logic [XLEN-1:0]  rd_lo_s;
    logic [XLEN-1:0]  rd_hi_s;
    logic             rd_hit_s;
    logic [XLEN-1:0]  hi_src_s;
    logic [XLEN-1:0]  rd_next_s;
    logic [XLEN-1:0]  rd_data_r;
    logic             rd_valid_r;

    // Out-of-range write indices match no channel and are dropped here.
    for (genvar g = 0; g < N_CNT; g++) begin : g_cell
        assign inc_en_s[g] = evt_i[g] & ~inhibit_i[g];
        assign wr_lo_s[g]  = wr_en_i & (wr_idx_i == 4'(g)) & ~wr_hi_i;
        assign wr_hi_s[g]  = wr_en_i & (wr_idx_i == 4'(g)) & wr_hi_i;

        perf_counter_cell #(
            .CNT_W (CNT_W),
            .XLEN  (XLEN)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .inc_en   (inc_en_s[g]),
            .wr_lo    (wr_lo_s[g]),
            .wr_hi    (wr_hi_s[g]),
            .wr_data  (wr_data_i),
            .count_lo (cnt_lo_s[g]),
            .count_hi (cnt_hi_s[g]),
            .ovf      (ovf_o[g])
        );
    end

    // Select the addressed channel's halves for the read port
    always_comb begin
        rd_lo_s  = {XLEN{1'b0}};
        rd_hi_s  = {XLEN{1'b0}};
        rd_hit_s = 1'b0;
        for (int k = 0; k < N_CNT; k++) begin
            rd_lo_s  = (rd_idx_i == 4'(k)) ? cnt_lo_s[k] : rd_lo_s;
            rd_hi_s  = (rd_idx_i == 4'(k)) ? cnt_hi_s[k] : rd_hi_s;
            rd_hit_s = (rd_idx_i == 4'(k)) | rd_hit_s;
        end
    end

`ifdef PERF_CNT_SNAPSHOT_EN
    logic [XLEN-1:0] snap_r;
    logic [3:0]      snap_idx_r;
    logic            snap_vld_r;

    // Latch the upper half whenever the lower half of a channel is read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_r     <= {XLEN{1'b0}};
            snap_idx_r <= 4'd0;
            snap_vld_r <= 1'b0;
        end else if (rd_en_i && rd_hit_s && !rd_hi_i) begin
            snap_r     <= rd_hi_s;
            snap_idx_r <= rd_idx_i;
            snap_vld_r <= 1'b1;
        end else begin
            snap_r     <= snap_r;
            snap_idx_r <= snap_idx_r;
            snap_vld_r <= snap_vld_r;
        end
    end

    assign hi_src_s = (snap_vld_r && (snap_idx_r == rd_idx_i)) ? snap_r : rd_hi_s;
`else
    assign hi_src_s = rd_hi_s;
`endif

    // Missing channels and a missing upper half read as zero
    always_comb begin
        rd_next_s = {XLEN{1'b0}};
        if (!rd_hit_s) begin
            rd_next_s = {XLEN{1'b0}};
        end else if (!rd_hi_i) begin
            rd_next_s = rd_lo_s;
        end else if (!WIDE) begin
            rd_next_s = {XLEN{1'b0}};
        end else begin
            rd_next_s = hi_src_s;
        end
    end

    // Registered read response, one cycle after the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r  <= {XLEN{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (rd_en_i) begin
            rd_data_r  <= rd_next_s;
            rd_valid_r <= 1'b1;
        end else begin
            rd_data_r  <= rd_data_r;
            rd_valid_r <= 1'b0;
        end
    end

    assign rd_data_o  = rd_data_r;
    assign rd_valid_o = rd_valid_r;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: reads push expected data, a monitor
// pops and compares on every rd_valid_o pulse.
module tb_perf_counter_bank;

    localparam int N  = 5;
    localparam int XL = 32;

    typedef struct {
        string           tag;
        logic [XL-1:0]   data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  evt_i;
    logic [N-1:0]  inhibit_i;
    logic          rd_en_i;
    logic [3:0]    rd_idx_i;
    logic          rd_hi_i;
    logic [XL-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          wr_en_i;
    logic [3:0]    wr_idx_i;
    logic          wr_hi_i;
    logic [XL-1:0] wr_data_i;
    logic [N-1:0]  ovf_o;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   wait_cnt = 0;

    perf_counter_bank #(.N_CNT(N), .CNT_W(64), .XLEN(XL)) dut (
        .clk        (clk),
        .rst        (rst),
        .evt_i      (evt_i),
        .inhibit_i  (inhibit_i),
        .rd_en_i    (rd_en_i),
        .rd_idx_i   (rd_idx_i),
        .rd_hi_i    (rd_hi_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .wr_en_i    (wr_en_i),
        .wr_idx_i   (wr_idx_i),
        .wr_hi_i    (wr_hi_i),
        .wr_data_i  (wr_data_i),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid_o pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (rd_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_valid_spurious: got valid with data 0x%0h, no read pending", rd_data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.tag, rd_data_o, e.data);
            end
            wait_cnt = 0;
        end else if (exp_q.size() != 0) begin
            wait_cnt++;
            if (wait_cnt > 1) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL %s: got no rd_valid_o within 1 cycle, expected data 0x%0h", e.tag, e.data);
                wait_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] idx, input logic hi, input logic [XL-1:0] exp, input string tag);
        rd_en_i  = 1'b1;
        rd_idx_i = idx;
        rd_hi_i  = hi;
        exp_q.push_back('{tag, exp});
        tick();
        rd_en_i = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [3:0] idx, input logic hi, input logic [XL-1:0] data);
        wr_en_i   = 1'b1;
        wr_idx_i  = idx;
        wr_hi_i   = hi;
        wr_data_i = data;
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic events(input logic [N-1:0] mask, input logic [N-1:0] inh, input int n);
        evt_i     = mask;
        inhibit_i = inh;
        repeat (n) tick();
        evt_i     = '0;
        inhibit_i = '0;
    endtask

    initial begin
        rst = 1'b1;
        evt_i = '0; inhibit_i = '0;
        rd_en_i = 1'b0; rd_idx_i = 4'd0; rd_hi_i = 1'b0;
        wr_en_i = 1'b0; wr_idx_i = 4'd0; wr_hi_i = 1'b0; wr_data_i = '0;
        #1;
        check("reset_rd_data", rd_data_o, 64'd0);
        check("reset_rd_valid", rd_valid_o, 64'd0);
        check("reset_ovf", ovf_o, 64'd0);
        #11;
        rst = 1'b0;
        tick();
        rd(4'd4, 1'b0, 32'h0, "reset_ch4_lo");

        // Lower-half wrap carries into the upper half without setting ovf
        wr(4'd0, 1'b0, 32'hFFFF_FFFF);
        events(5'b00001, 5'b00000, 1);
        rd(4'd0, 1'b0, 32'h0000_0000, "carry_ch0_lo");
        rd(4'd0, 1'b1, 32'h0000_0001, "carry_ch0_hi");
        check("carry_ovf0", ovf_o[0], 64'd0);

        // Full 64-bit wrap sets ovf; any write clears it
        wr(4'd2, 1'b0, 32'hFFFF_FFFF);
        wr(4'd2, 1'b1, 32'hFFFF_FFFF);
        events(5'b00100, 5'b00000, 1);
        rd(4'd2, 1'b0, 32'h0, "wrap_ch2_lo");
        rd(4'd2, 1'b1, 32'h0, "wrap_ch2_hi");
        check("wrap_ovf2_set", ovf_o, 64'b00100);
        wr(4'd2, 1'b0, 32'h7);
        check("wrap_ovf2_clear", ovf_o, 64'd0);
        rd(4'd2, 1'b0, 32'h7, "wr_ch2_lo");

        // Inhibit freezes the channel; a write wins over a same-cycle event
        events(5'b00010, 5'b00010, 10);
        rd(4'd1, 1'b0, 32'h0, "inhibit_ch1");
        evt_i = 5'b00010;
        wr(4'd1, 1'b0, 32'h5);
        evt_i = '0;
        rd(4'd1, 1'b0, 32'h5, "wr_beats_inc_ch1");
        wr(4'd1, 1'b1, 32'hA);
        rd(4'd1, 1'b0, 32'h5, "hi_wr_keeps_lo_ch1");
        rd(4'd1, 1'b1, 32'hA, "hi_wr_ch1");

        // Read returns the value before a same-cycle increment
        events(5'b01000, 5'b00000, 7);
        evt_i = 5'b01000;
        rd(4'd3, 1'b0, 32'd7, "rd_excl_inc_ch3");
        evt_i = '0;
        rd(4'd3, 1'b0, 32'd9, "after_inc_ch3");

        // Read and write of the same channel in one cycle sees the old value
        rd_en_i = 1'b1; rd_idx_i = 4'd3; rd_hi_i = 1'b0;
        wr_en_i = 1'b1; wr_idx_i = 4'd3; wr_hi_i = 1'b0; wr_data_i = 32'h55;
        exp_q.push_back('{"rd_wr_same_ch3", 32'd9});
        tick();
        rd_en_i = 1'b0; wr_en_i = 1'b0;
        tick();
        rd(4'd3, 1'b0, 32'h55, "post_wr_ch3");

        // Upper-half snapshot behaviour
        wr(4'd0, 1'b0, 32'hFFFF_FFFF);
        wr(4'd0, 1'b1, 32'h1);
        rd(4'd0, 1'b0, 32'hFFFF_FFFF, "snap_ch0_lo");
        events(5'b00001, 5'b00000, 1);
`ifdef PERF_CNT_SNAPSHOT_EN
        rd(4'd0, 1'b1, 32'h1, "snap_ch0_hi");
`else
        rd(4'd0, 1'b1, 32'h2, "live_ch0_hi");
`endif

        // Out-of-range index reads zero and writes touch nothing
        rd(4'd15, 1'b0, 32'h0, "oor_rd_15");
        rd(4'd5, 1'b1, 32'h0, "oor_rd_5_hi");
        wr(4'd15, 1'b0, 32'hDEAD_BEEF);
        wr(4'd5, 1'b0, 32'hDEAD_BEEF);
        rd(4'd0, 1'b0, 32'h0, "oor_keep_ch0");
        rd(4'd1, 1'b0, 32'h5, "oor_keep_ch1");
        rd(4'd2, 1'b0, 32'h7, "oor_keep_ch2");
        rd(4'd3, 1'b0, 32'h55, "oor_keep_ch3");
        rd(4'd4, 1'b0, 32'h0, "oor_keep_ch4");
        check("oor_ovf", ovf_o, 64'd0);

        // Several channels at once with a per-channel inhibit mask
        events(5'b11111, 5'b00010, 3);
        rd(4'd4, 1'b0, 32'd3, "multi_ch4");
        rd(4'd1, 1'b0, 32'd5, "multi_ch1_inhibited");
        rd(4'd2, 1'b0, 32'd10, "multi_ch2");

        // Asynchronous reset with a read in flight
        wr(4'd2, 1'b0, 32'hFFFF_FFFF);
        wr(4'd2, 1'b1, 32'hFFFF_FFFF);
        events(5'b00100, 5'b00000, 1);
        check("pre_rst_ovf2", ovf_o, 64'b00100);
        wr(4'd4, 1'b0, 32'd100);
        rd(4'd4, 1'b0, 32'd100, "pre_rst_ch4");
        rd_en_i = 1'b1; rd_idx_i = 4'd4; rd_hi_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rd_data", rd_data_o, 64'd0);
        check("async_rst_rd_valid", rd_valid_o, 64'd0);
        check("async_rst_ovf", ovf_o, 64'd0);
        rd_en_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_rd_valid", rd_valid_o, 64'd0);
        rd(4'd4, 1'b0, 32'h0, "post_rst_ch4");
        rd(4'd2, 1'b1, 32'h0, "post_rst_ch2_hi");

        repeat (3) tick();
        check("rd_queue_drained", exp_q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
